// File: rtl/digit_pkg.sv
// digit_pkg
// Shared types and constants for the digit-entry-to-byte converter.
//   state_t        : converter FSM states (IDLE / ACC / DONE)
//   DEC_BASE       : radix of decimal entry
//   MAX_DEC_DIGIT  : largest legal decimal digit
//   NUM_DIGITS     : digits per entry (hundreds, tens, units)
//   ACC_W          : decimal accumulator width (holds 999)
//   dec_digit_bad(): flags a nibble that is not a decimal digit
package digit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEC_BASE      = 10;
    localparam int MAX_DEC_DIGIT = 9;
    localparam int NUM_DIGITS    = 3;
    localparam int ACC_W         = 10;

    function automatic logic dec_digit_bad(input logic [3:0] d);
        return d > 4'(MAX_DEC_DIGIT);
    endfunction

endpackage

// File: rtl/mul10_add.sv
// mul10_add
// One Horner step for decimal entry: acc_out = acc_in * 10 + digit,
// built from two shifts and adds so no multiplier is inferred.
// Ports:
//   acc_in  [ACC_W-1:0] : running accumulator
//   digit   [3:0]       : digit being appended
//   acc_out [ACC_W-1:0] : updated accumulator (wraps at ACC_W bits)
module mul10_add
    import digit_pkg::*;
(
    input  logic [ACC_W-1:0] acc_in,
    input  logic [3:0]       digit,
    output logic [ACC_W-1:0] acc_out
);

    assign acc_out = (acc_in << 3) + (acc_in << 1) + ACC_W'(digit);

endmodule

// File: rtl/digit_entry_to_byte.sv
// digit_entry_to_byte
// Converts three entered digits (hundreds, tens, units) into one OUT_W-bit
// value. Hex entry completes in one cycle; decimal entry is accumulated one
// digit per clock with a multiply-by-10-and-add step.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   in_valid/in_ready : digit-set handshake (ready only while idle)
//   hex_mode          : 1 = hex nibbles, 0 = decimal digits
//   digit_h/ms/ls     : hundreds / tens (high nibble) / units (low nibble)
//   out_valid/out_ready : result handshake
//   out_value, out_err: result and its error flag (held after take)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a digit set, in_ready high
// ACC   | decimal accumulation, one digit per clock (h, ms, ls)
// DONE  | result presented, waiting for out_ready
module digit_entry_to_byte
    import digit_pkg::*;
#(
    parameter int OUT_W      = 8,
    parameter bit SAT_ON_ERR = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             hex_mode,
    input  logic [3:0]       digit_h,
    input  logic [3:0]       digit_ms,
    input  logic [3:0]       digit_ls,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_value,
    output logic             out_err
);

    localparam logic [ACC_W-1:0] MAX_VAL  = ACC_W'((2 ** OUT_W) - 1);
    localparam logic [1:0]       LAST_IDX = 2'(NUM_DIGITS - 1);

    state_t             state_q, state_nxt;
    logic [ACC_W-1:0]   acc_q, acc_nxt;
    logic [1:0]         idx_q, idx_nxt;
    logic               derr_q, derr_nxt;
    logic [3:0]         dig_h_q, dig_ms_q, dig_ls_q;
    logic               load_digits;
    logic [OUT_W-1:0]   val_q, val_nxt;
    logic               oerr_q, oerr_nxt;
    logic [3:0]         cur_digit;
    logic [ACC_W-1:0]   mac_out;
    logic               fin_err;

    always_comb begin
        unique case (idx_q)
            2'd0:    cur_digit = dig_h_q;
            2'd1:    cur_digit = dig_ms_q;
            default: cur_digit = dig_ls_q;
        endcase
    end

    mul10_add u_mul10_add (
        .acc_in  (acc_q),
        .digit   (cur_digit),
        .acc_out (mac_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        acc_nxt     = acc_q;
        idx_nxt     = idx_q;
        derr_nxt    = derr_q;
        val_nxt     = val_q;
        oerr_nxt    = oerr_q;
        load_digits = 1'b0;
        fin_err     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load_digits = 1'b1;
                    if (hex_mode) begin
                        state_nxt = DONE;
                        oerr_nxt  = (digit_h != 4'd0);
                        val_nxt   = (oerr_nxt && SAT_ON_ERR) ? '1
                                                             : OUT_W'({digit_ms, digit_ls});
                    end else begin
                        state_nxt = ACC;
                        acc_nxt   = '0;
                        idx_nxt   = 2'd0;
                        derr_nxt  = 1'b0;
                    end
                end
            end
            ACC: begin
                acc_nxt  = mac_out;
                derr_nxt = derr_q | dec_digit_bad(cur_digit);
                if (idx_q == LAST_IDX) begin
                    // Final digit: the result is judged on the freshly summed value.
                    state_nxt = DONE;
                    fin_err   = derr_nxt | (mac_out > MAX_VAL);
                    oerr_nxt  = fin_err;
                    val_nxt   = (fin_err && SAT_ON_ERR) ? '1 : mac_out[OUT_W-1:0];
                end else begin
                    idx_nxt = idx_q + 2'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            idx_q    <= 2'd0;
            derr_q   <= 1'b0;
            dig_h_q  <= 4'd0;
            dig_ms_q <= 4'd0;
            dig_ls_q <= 4'd0;
            val_q    <= '0;
            oerr_q   <= 1'b0;
        end else begin
            acc_q  <= acc_nxt;
            idx_q  <= idx_nxt;
            derr_q <= derr_nxt;
            val_q  <= val_nxt;
            oerr_q <= oerr_nxt;
            if (load_digits) begin
                dig_h_q  <= digit_h;
                dig_ms_q <= digit_ms;
                dig_ls_q <= digit_ls;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_value = val_q;
    assign out_err   = oerr_q;

endmodule

// File: tb/tb_digit_entry_to_byte.sv
// tb_digit_entry_to_byte
// Directed vector table plus hand-written sequences for backpressure,
// back-to-back operation and mid-conversion reset. Two instances share the
// inputs: one saturating on error, one truncating.
module tb_digit_entry_to_byte;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       hex_mode;
    logic [3:0] digit_h, digit_ms, digit_ls;
    logic       out_ready;

    logic       in_ready_s, out_valid_s, out_err_s;
    logic [7:0] out_value_s;
    logic       in_ready_t, out_valid_t, out_err_t;
    logic [7:0] out_value_t;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       hex;
        logic [3:0] h;
        logic [3:0] ms;
        logic [3:0] ls;
        logic [7:0] v_sat;
        logic [7:0] v_trunc;
        logic       err;
    } vec_t;

    vec_t vecs [10];

    digit_entry_to_byte #(.OUT_W(8), .SAT_ON_ERR(1'b1)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .hex_mode  (hex_mode),
        .digit_h   (digit_h),
        .digit_ms  (digit_ms),
        .digit_ls  (digit_ls),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .out_value (out_value_s),
        .out_err   (out_err_s)
    );

    digit_entry_to_byte #(.OUT_W(8), .SAT_ON_ERR(1'b0)) dut_trunc (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_t),
        .hex_mode  (hex_mode),
        .digit_h   (digit_h),
        .digit_ms  (digit_ms),
        .digit_ls  (digit_ls),
        .out_valid (out_valid_t),
        .out_ready (out_ready),
        .out_value (out_value_t),
        .out_err   (out_err_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Waits for out_valid; returns edges elapsed since the handshake edge.
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!out_valid_s && cyc < 12) begin
            step();
            cyc++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int cyc;
        check({tag, " in_ready_pre"}, int'(in_ready_s), 1);
        in_valid  = 1'b1;
        hex_mode  = v.hex;
        digit_h   = v.h;
        digit_ms  = v.ms;
        digit_ls  = v.ls;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        hex_mode = 1'($urandom);
        digit_h  = 4'($urandom);
        digit_ms = 4'($urandom);
        digit_ls = 4'($urandom);
        wait_valid(cyc);
        check({tag, " latency"}, cyc, v.hex ? 1 : 4);
        check({tag, " value_sat"}, int'(out_value_s), int'(v.v_sat));
        check({tag, " value_trunc"}, int'(out_value_t), int'(v.v_trunc));
        check({tag, " err"}, int'(out_err_s), int'(v.err));
        check({tag, " err_trunc"}, int'(out_err_t), int'(v.err));
        check({tag, " in_ready_busy"}, int'(in_ready_s), 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, " valid_after_take"}, int'(out_valid_s), 0);
        check({tag, " in_ready_after_take"}, int'(in_ready_s), 1);
        check({tag, " value_held"}, int'(out_value_s), int'(v.v_sat));
    endtask

    initial begin
        int cyc;

        //         hex   h     ms    ls    v_sat  v_trunc err
        vecs[0] = '{1'b0, 4'd2, 4'd5, 4'd5, 8'd255, 8'd255, 1'b0};
        vecs[1] = '{1'b0, 4'd2, 4'd5, 4'd6, 8'hFF,  8'h00,  1'b1};
        vecs[2] = '{1'b0, 4'd0, 4'hA, 4'd3, 8'hFF,  8'd103, 1'b1};
        vecs[3] = '{1'b1, 4'd0, 4'hA, 4'd3, 8'hA3,  8'hA3,  1'b0};
        vecs[4] = '{1'b1, 4'd1, 4'd0, 4'd0, 8'hFF,  8'h00,  1'b1};
        vecs[5] = '{1'b0, 4'd0, 4'd0, 4'd0, 8'd0,   8'd0,   1'b0};
        vecs[6] = '{1'b0, 4'd9, 4'd9, 4'd9, 8'hFF,  8'd231, 1'b1};
        vecs[7] = '{1'b1, 4'd0, 4'hF, 4'hF, 8'hFF,  8'hFF,  1'b0};
        vecs[8] = '{1'b0, 4'd1, 4'd2, 4'd8, 8'd128, 8'd128, 1'b0};
        vecs[9] = '{1'b0, 4'd0, 4'd3, 4'd7, 8'd37,  8'd37,  1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        hex_mode  = 1'b0;
        digit_h   = 4'd0;
        digit_ms  = 4'd0;
        digit_ls  = 4'd0;
        out_ready = 1'b0;
        step();
        step();
        check("rst in_ready", int'(in_ready_s), 1);
        check("rst out_valid", int'(out_valid_s), 0);
        check("rst out_value", int'(out_value_s), 0);
        check("rst out_err", int'(out_err_s), 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            step();
        end

        // Backpressure: result held, new requests ignored.
        in_valid = 1'b1; hex_mode = 1'b0;
        digit_h = 4'd1; digit_ms = 4'd2; digit_ls = 4'd3;
        step();
        in_valid = 1'b0;
        wait_valid(cyc);
        check("bp latency", cyc, 4);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            hex_mode = 1'b1;
            digit_h  = 4'($urandom);
            digit_ms = 4'($urandom);
            digit_ls = 4'($urandom);
            step();
            check("bp out_valid", int'(out_valid_s), 1);
            check("bp value", int'(out_value_s), 123);
            check("bp in_ready", int'(in_ready_s), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp idle after take", int'(in_ready_s), 1);
        check("bp value held", int'(out_value_s), 123);
        step();

        // Back-to-back with out_ready tied high.
        out_ready = 1'b1;
        in_valid  = 1'b1; hex_mode = 1'b0;
        digit_h = 4'd0; digit_ms = 4'd9; digit_ls = 4'd9;
        step();
        digit_h = 4'd0; digit_ms = 4'd0; digit_ls = 4'd7;
        wait_valid(cyc);
        check("b2b first latency", cyc, 4);
        check("b2b first value", int'(out_value_s), 99);
        step();
        check("b2b in_ready re-assert", int'(in_ready_s), 1);
        check("b2b valid drop", int'(out_valid_s), 0);
        step();
        in_valid = 1'b0;
        check("b2b second accepted", int'(in_ready_s), 0);
        wait_valid(cyc);
        check("b2b second latency", cyc, 4);
        check("b2b second value", int'(out_value_s), 7);
        check("b2b second err", int'(out_err_s), 0);
        step();
        check("b2b in_ready final", int'(in_ready_s), 1);
        out_ready = 1'b0;
        step();

        // Reset during ACC, after the first digit has been processed.
        in_valid = 1'b1; hex_mode = 1'b0;
        digit_h = 4'd3; digit_ms = 4'd3; digit_ls = 4'd3;
        step();
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_acc out_valid", int'(out_valid_s), 0);
        check("rst_acc in_ready", int'(in_ready_s), 1);
        check("rst_acc out_value", int'(out_value_s), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_vec('{1'b0, 4'd0, 4'd4, 4'd2, 8'd42, 8'd42, 1'b0}, "post_rst_acc");
        step();

        // Reset while an erroneous result sits in DONE.
        in_valid = 1'b1; hex_mode = 1'b0;
        digit_h = 4'd2; digit_ms = 4'd5; digit_ls = 4'd6;
        step();
        in_valid = 1'b0;
        wait_valid(cyc);
        check("rst_done pre err", int'(out_err_s), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_done out_valid", int'(out_valid_s), 0);
        check("rst_done out_err", int'(out_err_s), 0);
        check("rst_done out_value", int'(out_value_s), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rst_done stays idle", int'(out_valid_s), 0);
        run_vec('{1'b0, 4'd0, 4'd4, 4'd2, 8'd42, 8'd42, 1'b0}, "post_rst_done");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
